// File: rtl/multi_port_reg_file.sv
// Multi-ported architectural register file with optional write-to-read bypass,
// a per-register busy scoreboard and a sequenced clear engine.
module multi_port_reg_file #(
    parameter int              XLEN       = 32,
    parameter int              NUM_REGS   = 32,
    parameter int              NUM_READ   = 2,
    parameter int              NUM_WRITE  = 1,
    parameter int              BYPASS     = 1,
    parameter int              SP_INDEX   = 2,
    parameter logic [XLEN-1:0] INITIAL_SP = XLEN'(64*1024*1024-4),
    localparam int             AW         = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_READ*AW-1:0]    rd_addr,
    output logic [NUM_READ*XLEN-1:0]  rd_data,
    output logic [NUM_READ-1:0]       rd_busy,
    input  logic [NUM_WRITE-1:0]      wr_en,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0] wr_data,
    input  logic [NUM_WRITE-1:0]      wr_release,
    input  logic                      rsv_valid,
    input  logic [AW-1:0]             rsv_addr,
    input  logic                      clear_req,
    output logic                      clear_active,
    output logic                      clear_done
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLEARING = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic [NUM_REGS-1:0] win_en;
    logic [NUM_REGS-1:0] win_rel;
    logic [XLEN-1:0]     win_data [NUM_REGS];
    logic [AW-1:0]       rd_idx;

    function automatic logic [XLEN-1:0] reset_value(input int r);
        return (r == SP_INDEX && r != 0) ? INITIAL_SP : '0;
    endfunction

    // Per-register winning write; later ports overwrite earlier ones, so the
    // highest-index enabled port decides both data and release. Register 0 never wins.
    always_comb begin
        win_en  = '0;
        win_rel = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            win_data[r] = '0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r)) begin
                    win_en[r]   = 1'b1;
                    win_rel[r]  = wr_release[p];
                    win_data[r] = wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        regs_d    = regs_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (win_en[r]) begin
                        regs_d[r] = win_data[r];
                        if (win_rel[r]) begin
                            busy_d[r] = 1'b0;
                        end
                    end
                end
                // Applied after releases so a same-cycle reservation keeps the register busy.
                if (rsv_valid && rsv_addr != '0) begin
                    busy_d[rsv_addr] = 1'b1;
                end
                if (clear_req) begin
                    state_d   = ST_CLEARING;
                    clr_idx_d = AW'(1);
                end
            end
            ST_CLEARING: begin
                regs_d[clr_idx_q] = reset_value(int'(clr_idx_q));
                busy_d[clr_idx_q] = 1'b0;
                if (clr_idx_q == AW'(NUM_REGS-1)) begin
                    state_d = ST_DONE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= reset_value(r);
            end
            busy_q    <= '0;
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // During a clear every read reports busy and sees only stored contents.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_idx                  = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = regs_q[rd_idx];
            rd_busy[i]              = busy_q[rd_idx];
            if (state_q != ST_IDLE) begin
                rd_busy[i] = 1'b1;
            end else if (BYPASS != 0 && win_en[rd_idx]) begin
                rd_data[i*XLEN +: XLEN] = win_data[rd_idx];
                if (win_rel[rd_idx] && !(rsv_valid && rsv_addr == rd_idx)) begin
                    rd_busy[i] = 1'b0;
                end
            end
        end
    end

    assign clear_active = (state_q == ST_CLEARING);
    assign clear_done   = (state_q == ST_DONE);

endmodule
